// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor controller: runs one full-subtractor cell over WIDTH bits, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtract_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             inborrow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             overflow,
`endif
    output logic             outborrow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d, ob_q, ob_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic             abit, bbit, dbit, br_nxt, last, accept;
    logic [WIDTH-1:0] res_shift;

    // Operands shift right, so bit 0 always holds the bit being processed;
    // on the final bit it is the original MSB, which the overflow term needs.
    assign abit      = a_q[0];
    assign bbit      = b_q[0];
    assign dbit      = abit ^ bbit ^ br_q;
    assign br_nxt    = (~abit & bbit) | (~(abit ^ bbit) & br_q);
    assign res_shift = {dbit, res_q[WIDTH-1:1]};
    assign last      = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept    = (state_q != RUN) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            ob_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            ob_q    <= ob_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        diff_d = diff_q;
        cnt_d  = cnt_q;
        br_d   = br_q;
        ob_d   = ob_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (accept) begin
            a_d   = minuend;
            b_d   = subtrahend;
            br_d  = inborrow;
            cnt_d = '0;
            res_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            res_d = res_shift;
            if (last) begin
                diff_d = res_shift;
                ob_d   = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d  = (abit != bbit) && (dbit != abit);
`endif
            end
        end
    end

    assign diff      = diff_q;
    assign outborrow = ob_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow  = ovf_q;
`endif

endmodule
